// File: rtl/pi_link_defs.sv
// Shared definitions for the Raspberry Pi <-> FPGA GPIO serial link.
// Used by the receiver now and by the transmitter later.
package pi_link_defs;

  localparam int DEF_CLK_HZ = 50_000_000;
  localparam int DEF_BAUD   = 115_200;
  localparam int DATA_W     = 8;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = IDLE,
    ST_START     = START,
    ST_DATA      = DATA,
    ST_STOP      = STOP,
    ST_WAIT_IDLE = WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/pi_uart_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// RST_VAL lets each GPIO input reset to its own idle level.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] stage_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg <= {2{RST_VAL}};
    end else begin
      stage_reg <= {stage_reg[0], d};
    end
  end

  assign q = stage_reg[1];

endmodule

// File: rtl/pi_uart_rx.sv
// 8N1 UART receiver for the Pi -> FPGA GPIO link, oversampled on the board clock.
// Each good byte is held on data with a one-cycle valid strobe.
module pi_uart_rx
  import pi_link_defs::*;
#(
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int BAUD         = DEF_BAUD,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] FULL_TERM = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic              rxs;
  rx_state_t         state_reg;
  logic [CNT_W-1:0]  baud_cnt_reg;
  logic [2:0]        bit_idx_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] data_reg;
  logic              valid_reg;
  logic              frame_err_reg;
  logic              busy_reg;
  logic [CNT_W-1:0]  term;
  logic              tick;

  sync2 #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rxs)
  );

  // The start bit is checked at its middle, so every later sample lands mid-bit.
  always_comb begin
    term = FULL_TERM;
    if (state_reg == ST_START) begin
      term = HALF_TERM;
    end
  end

  assign tick = (baud_cnt_reg == term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      baud_cnt_reg  <= '0;
      bit_idx_reg   <= 3'd0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          baud_cnt_reg <= '0;
          if (!rxs) begin
            state_reg <= ST_START;
            busy_reg  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            baud_cnt_reg <= '0;
            if (!rxs) begin
              state_reg   <= ST_DATA;
              bit_idx_reg <= 3'd0;
            end else begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick) begin
            baud_cnt_reg <= '0;
            shift_reg    <= {rxs, shift_reg[DATA_W-1:1]};
            bit_idx_reg  <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= ST_STOP;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            baud_cnt_reg <= '0;
            if (rxs) begin
              data_reg  <= shift_reg;
              valid_reg <= 1'b1;
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= ST_WAIT_IDLE;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        // A held-low line (break) parks here instead of starting a new frame.
        ST_WAIT_IDLE: begin
          baud_cnt_reg <= '0;
          if (rxs) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          baud_cnt_reg <= '0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_pi_uart_rx.sv
// Directed bench for pi_uart_rx at 10 clocks per bit: frame table plus
// hand-written glitch, break and mid-frame reset sequences.
module tb_pi_uart_rx;

  localparam int CPB = 10;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int total;
  int bad;
  int cyc;
  int valid_cnt;
  int ferr_cnt;
  int both_cnt;
  int last_valid_cyc;

  typedef struct {
    logic [7:0] tx;
    logic       stop_bit;
    int         gap;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  pi_uart_rx #(
    .CLK_HZ(1000),
    .BAUD  (100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt      <= valid_cnt + 1;
      last_valid_cyc <= cyc;
    end
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (valid === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // Drives start, 8 data bits LSB first and the stop bit, checking busy mid-frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            output logic busy_ok, output int start_cyc);
    logic [9:0] bits;
    bits      = {stop_bit, b, 1'b0};
    busy_ok   = 1'b1;
    start_cyc = 0;
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (i == 0) start_cyc = cyc;
      if (i >= 4 && i <= 96 && busy !== 1'b1) busy_ok = 1'b0;
      rx = bits[i / CPB];
    end
  endtask

  task automatic frame_and_check(input string name, input logic [7:0] b,
                                 input logic stop_bit, input logic exp_valid,
                                 input logic [7:0] exp_data);
    int   v0, f0, sc;
    logic bok;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(b, stop_bit, bok, sc);
    @(negedge clk);
    rx = 1'b1;
    $display("frame %s tx=%02h stop=%0b -> data=%02h valid_pulses=%0d ferr_pulses=%0d",
             name, b, stop_bit, data, valid_cnt - v0, ferr_cnt - f0);
    check({name, " valid"}, valid_cnt - v0, {31'd0, exp_valid});
    check({name, " frame_err"}, ferr_cnt - f0, {31'd0, ~exp_valid});
    check({name, " data"}, {24'd0, data}, {24'd0, exp_data});
    check({name, " busy"}, {31'd0, bok}, 32'd1);
    if (exp_valid) check({name, " latency"}, ((last_valid_cyc - sc) >= 97 && (last_valid_cyc - sc) <= 99) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int   v0, f0, wait_cnt;
    logic busy_seen;
    total = 0; bad = 0; cyc = 0;
    valid_cnt = 0; ferr_cnt = 0; both_cnt = 0; last_valid_cyc = 0;

    vecs[0] = '{tx: 8'hA5, stop_bit: 1'b1, gap: 20, exp_valid: 1'b1, exp_data: 8'hA5};
    vecs[1] = '{tx: 8'h00, stop_bit: 1'b1, gap: 5,  exp_valid: 1'b1, exp_data: 8'h00};
    vecs[2] = '{tx: 8'hFF, stop_bit: 1'b1, gap: 0,  exp_valid: 1'b1, exp_data: 8'hFF};
    vecs[3] = '{tx: 8'h3C, stop_bit: 1'b1, gap: 7,  exp_valid: 1'b1, exp_data: 8'h3C};
    vecs[4] = '{tx: 8'h55, stop_bit: 1'b0, gap: 4,  exp_valid: 1'b0, exp_data: 8'h3C};
    vecs[5] = '{tx: 8'h81, stop_bit: 1'b1, gap: 6,  exp_valid: 1'b1, exp_data: 8'h81};

    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    $display("reset: data=%02h valid=%0b frame_err=%0b busy=%0b", data, valid, frame_err, busy);
    check("reset data", {24'd0, data}, 32'd0);
    check("reset valid", {31'd0, valid}, 32'd0);
    check("reset frame_err", {31'd0, frame_err}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // An idle line after reset must not look like a start bit.
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    check("post-reset idle busy", {31'd0, busy_seen}, 32'd0);

    for (int k = 0; k < 6; k++) begin
      idle(vecs[k].gap);
      frame_and_check($sformatf("vec%0d", k), vecs[k].tx, vecs[k].stop_bit,
                      vecs[k].exp_valid, vecs[k].exp_data);
    end

    // Short low glitch: rejected at the half-bit check.
    idle(20);
    v0 = valid_cnt; f0 = ferr_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    @(negedge clk);
    rx = 1'b1;
    wait_cnt = 0;
    while (busy !== 1'b0 && wait_cnt < 8) begin
      @(negedge clk);
      wait_cnt++;
    end
    idle(15);
    $display("glitch: busy_wait=%0d valid_pulses=%0d ferr_pulses=%0d", wait_cnt, valid_cnt - v0, ferr_cnt - f0);
    check("glitch busy clears", {31'd0, busy}, 32'd0);
    check("glitch valid", valid_cnt - v0, 32'd0);
    check("glitch frame_err", ferr_cnt - f0, 32'd0);
    frame_and_check("after glitch", 8'h3C, 1'b1, 1'b1, 8'h3C);

    // Break: line low for 30 bit times.
    idle(10);
    v0 = valid_cnt; f0 = ferr_cnt;
    for (int i = 0; i < 30 * CPB; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    $display("break: busy=%0b valid_pulses=%0d ferr_pulses=%0d", busy, valid_cnt - v0, ferr_cnt - f0);
    check("break busy held", {31'd0, busy}, 32'd1);
    idle(6);
    check("break frame_err", ferr_cnt - f0, 32'd1);
    check("break valid", valid_cnt - v0, 32'd0);
    check("break busy release", {31'd0, busy}, 32'd0);
    frame_and_check("after break", 8'h12, 1'b1, 1'b1, 8'h12);

    // Reset asserted midway through data bit 4 of 0xF0.
    idle(20);
    v0 = valid_cnt; f0 = ferr_cnt;
    begin
      logic [9:0] bits;
      bits = {1'b1, 8'hF0, 1'b0};
      for (int i = 0; i < 55; i++) begin
        @(negedge clk);
        rx = bits[i / CPB];
      end
    end
    @(negedge clk);
    rx  = 1'b1;
    rst = 1'b1;
    #1;
    $display("mid-frame reset: data=%02h busy=%0b valid=%0b", data, busy, valid);
    check("midreset data", {24'd0, data}, 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(60);
    check("midreset valid", valid_cnt - v0, 32'd0);
    check("midreset frame_err", ferr_cnt - f0, 32'd0);
    check("midreset data after", {24'd0, data}, 32'd0);
    frame_and_check("after reset", 8'h7E, 1'b1, 1'b1, 8'h7E);

    idle(5);
    check("valid and frame_err overlap", both_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pi_uart_rx.md
Name: pi_uart_rx

Overview:
- Serial byte receiver for the Raspberry Pi -> FPGA direction on the GPIO21 link (PIN_D3).
- Recovers 8N1 UART frames and presents each received byte with a one-cycle valid strobe.
- The byte is also held for the LED/segment display path in the top level, as an alternative data source to the free-running counter.
- Runs entirely on the board clock and oversamples the line; there is no Pi-side clock.

Parameters:
- CLK_HZ, 50000000: frequency of clk in Hz.
- BAUD, 115200: line bit rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (434 at defaults): clk cycles per bit, integer-truncated. Legal minimum is 4.

Ports:
- clk  in  1  board clock, 50 MHz.
- rst  in  1  reset. Asynchronous, active-high; clears all state immediately.
- rx  in  1  serial line from the Pi GPIO. Asynchronous to clk; idles high.
- data  out  8  last good received byte. Held until the next good frame.
- valid  out  1  one-cycle pulse when data is updated.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- busy  out  1  high from detection of the start bit until return to IDLE.

Behaviour:
- Reset values:
  - data = 8'h00, valid = 0, frame_err = 0, busy = 0.
  - Synchronizer flops = 1 (line idle).
  - State = IDLE; bit counter and baud counter = 0.
- Synchronization:
  - rx passes through a 2-flop synchronizer; all logic uses the synchronized value rxs.
  - This adds 2 cycles of input latency.
- Baud counter: width clog2(CLKS_PER_BIT). Counts up to CLKS_PER_BIT-1 and wraps to 0; a "tick" is the cycle it reaches the terminal value.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: busy = 0. On rxs == 0 -> START, baud counter loaded for a half bit (terminal value CLKS_PER_BIT/2 - 1), busy = 1.
  - START: at the half-bit tick, sample rxs.
    - rxs == 0 -> DATA, bit index = 0, baud counter reset to a full bit.
    - rxs == 1 -> glitch: back to IDLE, no strobe, busy drops next cycle.
  - DATA: at each full-bit tick, shift rxs in LSB-first. After bit index 7 is sampled -> STOP.
  - STOP: at the full-bit tick, sample rxs.
    - rxs == 1: data <= shift register, valid = 1 for exactly the following cycle, -> IDLE.
    - rxs == 0: frame_err = 1 for exactly the following cycle, data unchanged, -> WAIT_IDLE.
  - WAIT_IDLE: remain until rxs == 1, then -> IDLE. This absorbs a break (line held low) without re-triggering.
- Latency: valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rx falling edge (±1 cycle of sync phase).
- valid and frame_err are never high in the same cycle.
- The shift register is not cleared between frames. Only data is architecturally visible.
- Back-to-back frames: a new start bit detected on the first IDLE cycle after STOP must be accepted. Stop-bit tolerance is half a bit.
- Reset mid-frame: asynchronous return to the reset values. A partial frame produces no strobe. The next full frame after reset release must be received correctly.
- No internal FIFO: a consumer that misses valid loses the strobe, but data remains readable until overwritten.

Decomposition:
- Shared include/package `pi_link_defs`:
  - state encoding localparams (IDLE = 0, START = 1, DATA = 2, STOP = 3, WAIT_IDLE = 4, 3-bit);
  - default CLK_HZ and BAUD;
  - the data width constant of 8, shared with a future pi_uart_tx.
- One sub-module: `sync2`, a parameterized-reset-value 2-flop bit synchronizer (reset value 1 here). It is reusable for the other GPIO inputs.

Test Plan (sim: CLK_HZ = 1000, BAUD = 100, so CLKS_PER_BIT = 10):
- Send 0xA5 8N1 after 20 idle cycles -> data = 8'hA5, valid high exactly 1 cycle, 98 ± 1 cycles after the start edge. frame_err stays 0; busy = 1 throughout the frame.
- Send 0x00 immediately followed by 0xFF (no idle gap) -> two valid pulses; data = 00 then FF; no frame_err.
- Pulse rx low for 3 cycles, then high -> no valid, no frame_err; busy returns to 0 within 8 cycles; the next 0x3C frame is received correctly.
- Send 0x55 with the stop bit driven 0 -> frame_err pulses once, valid stays 0, data keeps its prior value (0x3C). After rx returns high, a 0x81 frame gives data = 0x81.
- Hold rx low for 30 bit times (break), then release -> exactly one frame_err pulse and no valid. The FSM sits in WAIT_IDLE until release; the next 0x12 frame is received.
- Assert rst for 2 cycles midway through bit 4 of 0xF0 -> data = 00, busy = 0 immediately, no strobe. After release, 0x7E is received correctly.
